// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, register-file constants and the
// ALUOp field width used by ID_EX and the control unit.
package pipeline_pkg;

    localparam logic ST_RUN   = 1'b0;
    localparam logic ST_STALL = 1'b1;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int unsigned ALUOP_W = 2;

    typedef enum logic {
        StRun   = ST_RUN,
        StStall = ST_STALL
    } hz_state_e;

    // Load-use hazard between the load in EX and the instruction in ID; $0 never hazards.
    function automatic logic load_use_hazard(
        input logic       ex_mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        return ex_mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that saturates at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    // Synchronous clear; count up while below the maximum.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use stall and taken-branch flush controller for the 5-stage MIPS pipeline.
module hazard_stall_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             mem_branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_flush,
    output logic             stalling,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [3:0] REM_INIT = 4'(LOAD_STALL_CYCLES - 1);

    hz_state_e  state_q;
    logic [3:0] rem_q;
    logic       hz;
    logic       stall_inc;
    logic       flush_inc;

    assign hz = load_use_hazard(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);

    // Control decision from the current state and inputs; a taken branch overrides any stall.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_flush = 1'b0;
        stalling     = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_flush = 1'b1;
        end else begin
            stalling = (state_q == StStall);
            if (mem_branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                ex_mem_flush = 1'b1;
                flush_inc    = 1'b1;
            end else if ((state_q == StStall) || hz) begin
                // hz is only looked at in RUN; STALL holds regardless of the inputs.
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                stall_inc    = 1'b1;
            end
        end
    end

    // FSM state and remaining-bubble counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            rem_q   <= 4'd0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (!mem_branch_taken && hz) begin
                        rem_q   <= REM_INIT;
                        state_q <= (LOAD_STALL_CYCLES > 1) ? StStall : StRun;
                    end
                end
                StStall: begin
                    if (mem_branch_taken) begin
                        rem_q   <= 4'd0;
                        state_q <= StRun;
                    end else begin
                        rem_q <= rem_q - 4'd1;
                        if (rem_q <= 4'd1) begin
                            state_q <= StRun;
                        end
                    end
                end
                default: begin
                    state_q <= StRun;
                    rem_q   <= 4'd0;
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (stall_inc),
        .count(stall_cnt)
    );

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (flush_inc),
        .count(flush_cnt)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: three instances covering 1-cycle stalls, 3-cycle stalls
// and 2-bit saturating counters. Inputs change at negedge; outputs are checked 1 ns later.
module tb_hazard_stall_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       mr;
        logic [4:0] ex_rt;
        logic       br;
    } in_t;

    // ctl bits: {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, stalling}
    typedef struct packed {
        in_t         in;
        logic [5:0]  ctl;
        logic [15:0] scnt;
        logic [15:0] fcnt;
    } vec_t;

    localparam logic [5:0] C_RUN   = 6'b110000;
    localparam logic [5:0] C_HZ    = 6'b000100;
    localparam logic [5:0] C_STALL = 6'b000101;
    localparam logic [5:0] C_FLUSH = 6'b111110;
    localparam logic [5:0] C_FLST  = 6'b111111;
    localparam logic [5:0] C_RST   = 6'b001110;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    in_t in_a, in_b, in_c;
    logic [5:0]  ctl_a, ctl_b, ctl_c;
    logic [15:0] scnt_a, fcnt_a, scnt_b, fcnt_b;
    logic [1:0]  scnt_c, fcnt_c;

    hazard_stall_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(in_a.rst), .id_rs(in_a.rs), .id_rt(in_a.rt),
        .id_uses_rt(in_a.uses_rt), .ex_mem_read(in_a.mr), .ex_rt(in_a.ex_rt),
        .mem_branch_taken(in_a.br), .pc_write(ctl_a[5]), .if_id_write(ctl_a[4]),
        .if_id_flush(ctl_a[3]), .id_ex_bubble(ctl_a[2]), .ex_mem_flush(ctl_a[1]),
        .stalling(ctl_a[0]), .stall_cnt(scnt_a), .flush_cnt(fcnt_a)
    );

    hazard_stall_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) u_b (
        .clk(clk), .rst(in_b.rst), .id_rs(in_b.rs), .id_rt(in_b.rt),
        .id_uses_rt(in_b.uses_rt), .ex_mem_read(in_b.mr), .ex_rt(in_b.ex_rt),
        .mem_branch_taken(in_b.br), .pc_write(ctl_b[5]), .if_id_write(ctl_b[4]),
        .if_id_flush(ctl_b[3]), .id_ex_bubble(ctl_b[2]), .ex_mem_flush(ctl_b[1]),
        .stalling(ctl_b[0]), .stall_cnt(scnt_b), .flush_cnt(fcnt_b)
    );

    hazard_stall_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(2)) u_c (
        .clk(clk), .rst(in_c.rst), .id_rs(in_c.rs), .id_rt(in_c.rt),
        .id_uses_rt(in_c.uses_rt), .ex_mem_read(in_c.mr), .ex_rt(in_c.ex_rt),
        .mem_branch_taken(in_c.br), .pc_write(ctl_c[5]), .if_id_write(ctl_c[4]),
        .if_id_flush(ctl_c[3]), .id_ex_bubble(ctl_c[2]), .ex_mem_flush(ctl_c[1]),
        .stalling(ctl_c[0]), .stall_cnt(scnt_c), .flush_cnt(fcnt_c)
    );

    function automatic in_t mk(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                               input logic uses_rt, input logic mr, input logic [4:0] ex_rt,
                               input logic br);
        in_t v;
        v.rst = rst; v.rs = rs; v.rt = rt; v.uses_rt = uses_rt;
        v.mr = mr; v.ex_rt = ex_rt; v.br = br;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus to all three instances.
    task automatic drive(input in_t a, input in_t b, input in_t c);
        @(negedge clk);
        in_a = a;
        in_b = b;
        in_c = c;
        #1;
    endtask

    vec_t vecs[13];
    in_t  idle, rst_in, hz_in, br_in;

    initial begin
        idle   = mk(0, 0, 0, 0, 0, 0, 0);
        rst_in = mk(1, 0, 0, 0, 0, 0, 0);
        hz_in  = mk(0, 5'd2, 0, 0, 1, 5'd2, 0);
        br_in  = mk(0, 0, 0, 0, 0, 0, 1);

        // Single-cycle stall table for u_a; counter values are those before the edge.
        vecs[0]  = '{mk(1, 0, 0, 0, 0, 0, 0),          C_RST,   16'd0, 16'd0};
        vecs[1]  = '{mk(0, 0, 0, 0, 0, 0, 0),          C_RUN,   16'd0, 16'd0};
        vecs[2]  = '{mk(0, 5'd2, 0, 0, 1, 5'd2, 0),    C_HZ,    16'd0, 16'd0};
        vecs[3]  = '{mk(0, 5'd2, 0, 0, 0, 5'd2, 0),    C_RUN,   16'd1, 16'd0};
        vecs[4]  = '{mk(0, 0, 0, 1, 1, 0, 0),          C_RUN,   16'd1, 16'd0};
        vecs[5]  = '{mk(0, 0, 5'd5, 1, 1, 5'd5, 1),    C_FLUSH, 16'd1, 16'd0};
        vecs[6]  = '{mk(0, 0, 0, 0, 0, 0, 0),          C_RUN,   16'd1, 16'd1};
        vecs[7]  = '{mk(0, 5'd3, 5'd5, 0, 1, 5'd5, 0), C_RUN,   16'd1, 16'd1};
        vecs[8]  = '{mk(0, 5'd3, 5'd5, 1, 1, 5'd5, 0), C_HZ,    16'd1, 16'd1};
        vecs[9]  = '{mk(0, 0, 0, 0, 0, 0, 0),          C_RUN,   16'd2, 16'd1};
        vecs[10] = '{mk(0, 5'd2, 0, 0, 0, 5'd2, 0),    C_RUN,   16'd2, 16'd1};
        vecs[11] = '{mk(0, 0, 0, 0, 0, 0, 1),          C_FLUSH, 16'd2, 16'd1};
        vecs[12] = '{mk(0, 0, 0, 0, 0, 0, 0),          C_RUN,   16'd2, 16'd2};

        in_a = rst_in; in_b = rst_in; in_c = rst_in;
        repeat (2) @(posedge clk);

        // u_a table; u_b and u_c held in reset meanwhile (forced outputs checked too).
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].in, rst_in, rst_in);
            chk($sformatf("a_ctl[%0d]", i), 32'(ctl_a), 32'(vecs[i].ctl));
            chk($sformatf("a_scnt[%0d]", i), 32'(scnt_a), 32'(vecs[i].scnt));
            chk($sformatf("a_fcnt[%0d]", i), 32'(fcnt_a), 32'(vecs[i].fcnt));
        end
        chk("b_rst_ctl", 32'(ctl_b), 32'(C_RST));
        chk("b_rst_scnt", 32'(scnt_b), 0);

        // u_b: three-cycle stall from a one-cycle hazard pulse.
        drive(idle, hz_in, rst_in);
        chk("b3_c1_ctl", 32'(ctl_b), 32'(C_HZ));
        drive(idle, idle, rst_in);
        chk("b3_c2_ctl", 32'(ctl_b), 32'(C_STALL));
        chk("b3_c2_scnt", 32'(scnt_b), 1);
        drive(idle, idle, rst_in);
        chk("b3_c3_ctl", 32'(ctl_b), 32'(C_STALL));
        chk("b3_c3_scnt", 32'(scnt_b), 2);
        drive(idle, idle, rst_in);
        chk("b3_c4_ctl", 32'(ctl_b), 32'(C_RUN));
        chk("b3_c4_scnt", 32'(scnt_b), 3);

        // u_b: branch on the second stall cycle aborts the stall.
        drive(idle, rst_in, rst_in);
        chk("b_rst2_ctl", 32'(ctl_b), 32'(C_RST));
        drive(idle, hz_in, rst_in);
        chk("bab_c1_ctl", 32'(ctl_b), 32'(C_HZ));
        chk("bab_c1_scnt", 32'(scnt_b), 0);
        drive(idle, br_in, rst_in);
        chk("bab_c2_ctl", 32'(ctl_b), 32'(C_FLST));
        drive(idle, idle, rst_in);
        chk("bab_c3_ctl", 32'(ctl_b), 32'(C_RUN));
        chk("bab_c3_scnt", 32'(scnt_b), 1);
        chk("bab_c3_fcnt", 32'(fcnt_b), 1);

        // u_b: reset mid-stall discards remaining bubbles and clears counters.
        drive(idle, hz_in, rst_in);
        drive(idle, idle, rst_in);
        chk("brs_stall_ctl", 32'(ctl_b), 32'(C_STALL));
        drive(idle, rst_in, rst_in);
        chk("brs_rst_ctl", 32'(ctl_b), 32'(C_RST));
        drive(idle, idle, rst_in);
        chk("brs_after_ctl", 32'(ctl_b), 32'(C_RUN));
        chk("brs_after_scnt", 32'(scnt_b), 0);
        chk("brs_after_fcnt", 32'(fcnt_b), 0);

        // u_c: 2-bit counters saturate at 3.
        for (int i = 0; i < 5; i++) begin
            drive(idle, idle, hz_in);
            chk($sformatf("c_hz_ctl[%0d]", i), 32'(ctl_c), 32'(C_HZ));
            chk($sformatf("c_scnt[%0d]", i), 32'(scnt_c), (i > 3) ? 3 : i);
        end
        for (int i = 0; i < 5; i++) begin
            drive(idle, idle, br_in);
            chk($sformatf("c_fcnt[%0d]", i), 32'(fcnt_c), (i > 3) ? 3 : i);
        end
        drive(idle, idle, idle);
        chk("c_scnt_sat", 32'(scnt_c), 3);
        chk("c_fcnt_sat", 32'(fcnt_c), 3);
        chk("c_idle_ctl", 32'(ctl_c), 32'(C_RUN));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS datapath. It sequences the PC, IF_ID, ID_EX and EX_MEM registers.
- Detects load-use hazards between the ID and EX stages and inserts bubbles into ID_EX. It holds the PC and IF_ID during a stall.
- Flushes the younger stages when a branch resolves taken in MEM.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- LOAD_STALL_CYCLES, 1, number of bubble cycles inserted per load-use hazard (1..15; >1 models slow data memory).
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- id_rs  in  5  rs field of the instruction in ID (ins25_21)
- id_rt  in  5  rt field of the instruction in ID (ins20_16)
- id_uses_rt  in  1  ID instruction reads rt as a source (R-type, beq, sw)
- ex_mem_read  in  1  MemReadOUT of ID_EX (load in EX)
- ex_rt  in  5  ins20_16OUT of ID_EX (load destination)
- mem_branch_taken  in  1  BranchOUT of EX_MEM AND zero flag
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF_ID load enable
- if_id_flush  out  1  zero IF_ID contents on the next edge
- id_ex_bubble  out  1  force all ID_EX control inputs (RegDst..RegWrite, ALUOp) to 0
- ex_mem_flush  out  1  zero EX_MEM control fields on the next edge
- stalling  out  1  FSM is in STALL
- stall_cnt  out  CNT_W  number of bubble cycles inserted, saturating
- flush_cnt  out  CNT_W  number of taken-branch flush events, saturating

Behaviour:
- Hazard term: hz = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
- FSM states: RUN, STALL. A down-counter rem[3:0] is used in STALL. The state is registered. Control outputs are combinational from the state and the current inputs and take effect at the next clk edge.
- RUN, mem_branch_taken=1:
  - if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1, pc_write=1 (the PC takes the branch target), if_id_write=1.
  - flush_cnt+1. Stay in RUN.
  - Branch beats hz in the same cycle; no stall is started.
- RUN, hz=1, no branch:
  - pc_write=0, if_id_write=0, id_ex_bubble=1.
  - stall_cnt+1. rem<=LOAD_STALL_CYCLES-1.
  - Next state is STALL if LOAD_STALL_CYCLES>1, else RUN.
- RUN, otherwise: pc_write=1, if_id_write=1, all flush/bubble outputs 0.
- STALL, no branch:
  - pc_write=0, if_id_write=0, id_ex_bubble=1, stall_cnt+1, rem<=rem-1.
  - rem==1 goes to RUN next cycle.
  - hz is not re-evaluated in STALL; the held ID instruction is re-checked in RUN.
- STALL, mem_branch_taken=1:
  - The stall is aborted. Flush outputs are asserted exactly as in the RUN branch case, with pc_write=1.
  - flush_cnt+1. stall_cnt is not incremented. Next state is RUN, rem<=0.
- stalling=1 only in STALL.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset (rst high at an edge): state<=RUN, rem<=0, stall_cnt<=0, flush_cnt<=0.
- While rst is high, outputs are forced: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1, stalling=0. The pipeline is held clean.
- Reset mid-stall discards the remaining stall cycles.
- Stage latency: zero-cycle combinational decision; one registered state update per edge.

Decomposition:
- Shared package pipeline_pkg: state encoding constants (ST_RUN=0, ST_STALL=1) and REG_ZERO=5'd0. The 2-bit ALUOp width constant also goes there and is shared with ID_EX and the control unit.
- One natural sub-module, sat_counter (CNT_W, inc, rst, clk), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- lw $2 in EX (ex_mem_read=1, ex_rt=2), ID add with id_rs=2, LOAD_STALL_CYCLES=1 -> one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1. The next cycle with ex_mem_read=0 returns to pc_write=1. stall_cnt=1.
- ex_rt=0, id_rs=0, ex_mem_read=1 -> no stall; all enables 1, stall_cnt stays 0.
- Same cycle: hz=1 (ex_rt=5, id_rt=5, id_uses_rt=1) and mem_branch_taken=1 -> if_id_flush=1, ex_mem_flush=1, id_ex_bubble=1, pc_write=1. flush_cnt=1, stall_cnt=0.
- LOAD_STALL_CYCLES=3 and hz pulse -> stalling high for cycles 2-3. pc_write=0 for exactly 3 cycles, stall_cnt=3.
- LOAD_STALL_CYCLES=3, mem_branch_taken on the 2nd stall cycle -> flush asserted that cycle, RUN next. stall_cnt=1, flush_cnt=1.
- CNT_W=2 with 5 hazards -> stall_cnt saturates at 3. Asserting rst mid-STALL -> next cycle state RUN, counters 0, forced reset outputs while rst is high.
